// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch slice: FSM states, opcode constants
// and the next-PC source selection helper.
package instr_fetch_unit_pkg;

  localparam int OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_ADD = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_SUB = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_BEQ = 6'b000100;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_JREG   = 2'd3
  } npc_sel_e;

  // Register jumps beat direct jumps, which beat a taken branch.
  function automatic npc_sel_e select_npc(input logic jump_reg, input logic jump,
                                          input logic branch, input logic zero);
    if (jump_reg)           return NPC_JREG;
    else if (jump)          return NPC_JUMP;
    else if (branch && zero) return NPC_BRANCH;
    else                    return NPC_SEQ;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: sequential, taken branch, direct jump or register jump.
module next_pc_calc
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] ir,
  input  logic [DATA_W-1:0] rs_value,
  input  logic              branch,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic              zero,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] offset;
  logic              unused_bits;

  // Only the low address bits of the targets matter; the rest is dropped on purpose.
  assign unused_bits = ^{ir, rs_value};
  assign seq_pc      = pc + ADDR_W'(1);

  // Sign-extend the 16-bit immediate to (or truncate it at) the address width.
  always_comb begin
    offset = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      offset[i] = (i < 16) ? ir[i] : ir[15];
    end
  end

  always_comb begin
    next_pc = seq_pc;
    unique case (select_npc(jump_reg, jump, branch, zero))
      NPC_JREG:   next_pc = rs_value[ADDR_W-1:0];
      NPC_JUMP:   next_pc = ir[ADDR_W-1:0];
      NPC_BRANCH: next_pc = seq_pc + offset;
      default:    next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches one instruction at a time from instruction memory, presents it to the decoder
// and advances the PC from the decoder's control outputs once downstream accepts it.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                 ADDR_W   = 8,
  parameter int                 DATA_W   = 32,
  parameter int                 OPC_W    = OPCODE_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [OPC_W-1:0]  opcode,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              stall,
  input  logic              branch,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic              zero,
  input  logic [DATA_W-1:0] rs_value,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_e      state;
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] next_pc;

  next_pc_calc #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_next_pc_calc (
    .pc       (pc),
    .ir       (ir),
    .rs_value (rs_value),
    .branch   (branch),
    .jump     (jump),
    .jump_reg (jump_reg),
    .zero     (zero),
    .next_pc  (next_pc)
  );

  // The fetch address is the PC itself, so it cannot move while a request is pending.
  assign imem_addr = pc;
  assign instr     = ir;
  assign opcode    = ir[DATA_W-1 -: OPC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RESET;
      pc          <= RESET_PC;
      ir          <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      unique case (state)
        S_RESET: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir          <= imem_rdata;
            state       <= S_ISSUE;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        S_ISSUE: begin
          // Decoder controls are only consulted on the edge the issue is accepted.
          if (!stall) begin
            pc          <= next_pc;
            state       <= S_FETCH;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= S_RESET;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench: the memory driver pushes each returned word, a monitor pops on every new issue.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [5:0]  opcode;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        branch;
  logic        jump;
  logic        jump_reg;
  logic        zero;
  logic [31:0] rs_value;
  logic [7:0]  pc;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] word;
  } issue_t;

  issue_t expQ[$];
  logic   prevValid = 1'b0;

  instr_fetch_unit #(
    .ADDR_W   (8),
    .DATA_W   (32),
    .OPC_W    (6),
    .RESET_PC (8'h00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .opcode      (opcode),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .branch      (branch),
    .jump        (jump),
    .jump_reg    (jump_reg),
    .zero        (zero),
    .rs_value    (rs_value),
    .pc          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic waitReq(input string name, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req) begin
        seen = 1'b1;
        return;
      end
    end
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: imem_req never asserted, got 0, expected 1", name);
  endtask

  // One full fetch/issue round: memory answers after ackDelay, downstream stalls, then
  // the decoder controls are presented for the single accepting edge.
  task automatic applyStimulus(input string name, input logic [7:0] expAddr, input logic [31:0] word,
                               input int ackDelay, input int stallCycles,
                               input logic br, input logic jp, input logic jr, input logic zr,
                               input logic [31:0] rs);
    bit seen;
    logic [5:0] expOpc;
    expOpc = word[31:26];
    waitReq(name, seen);
    if (!seen) return;
    checkOutput({name, "_addr"}, 32'(imem_addr), 32'(expAddr));
    for (int i = 0; i < ackDelay; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({name, "_wait_req"}, 32'(imem_req), 32'd1);
      checkOutput({name, "_wait_addr"}, 32'(imem_addr), 32'(expAddr));
      checkOutput({name, "_wait_valid"}, 32'(instr_valid), 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    expQ.push_back('{pc: expAddr, word: word});
    @(posedge clk);
    #1;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    for (int i = 0; i < stallCycles; i++) begin
      @(negedge clk);
      checkOutput({name, "_stall_valid"}, 32'(instr_valid), 32'd1);
      checkOutput({name, "_stall_req"}, 32'(imem_req), 32'd0);
      checkOutput({name, "_stall_opc"}, 32'(opcode), 32'(expOpc));
      @(posedge clk);
    end
    @(negedge clk);
    stall    = 1'b0;
    branch   = br;
    jump     = jp;
    jump_reg = jr;
    zero     = zr;
    rs_value = rs;
    @(posedge clk);
    #1;
    stall    = 1'b1;
    branch   = 1'b0;
    jump     = 1'b0;
    jump_reg = 1'b0;
    zero     = 1'b0;
    rs_value = '0;
  endtask

  // Monitor: every rising edge of instr_valid must match the oldest outstanding fetch.
  initial begin
    issue_t e;
    forever begin
      @(negedge clk);
      if (instr_valid && !prevValid) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_issue: got instr %h, expected no issue", instr);
        end else begin
          e = expQ.pop_front();
          checkOutput("issue_pc", 32'(pc), 32'(e.pc));
          checkOutput("issue_instr", instr, e.word);
          checkOutput("issue_opcode", 32'(opcode), 32'(e.word[31:26]));
        end
      end
      prevValid = instr_valid;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    stall      = 1'b1;
    branch     = 1'b0;
    jump       = 1'b0;
    jump_reg   = 1'b0;
    zero       = 1'b0;
    rs_value   = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_opcode", 32'(opcode), 32'd0);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_pc", 32'(pc), 32'd0);
    checkOutput("rst_addr", 32'(imem_addr), 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("first_req", 32'(imem_req), 32'd1);
    checkOutput("first_addr", 32'(imem_addr), 32'd0);

    // Asynchronous reset in the middle of a pending fetch.
    rst_n = 1'b0;
    #1;
    checkOutput("midfetch_rst_req", 32'(imem_req), 32'd0);
    checkOutput("midfetch_rst_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //            name     addr   word           dly stl br    jp    jr    zr    rs
    applyStimulus("add0",  8'h00, 32'h0000_0020, 0,  0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("lw1",   8'h01, 32'h2022_0005, 3,  0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("sub2",  8'h02, 32'h0800_0022, 0,  0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("inv3",  8'h03, 32'hFC00_0000, 1,  0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("beq4t", 8'h04, 32'h1000_FFFE, 0,  0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    applyStimulus("add3",  8'h03, 32'h0000_0020, 0,  0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("beq4n", 8'h04, 32'h1000_FFFE, 0,  0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("jr5",   8'h05, 32'h0800_0040, 0,  0,  1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_01F0);
    applyStimulus("jmpF0", 8'hF0, 32'h0800_0040, 0,  0,  1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
    applyStimulus("jmp40", 8'h40, 32'h0800_00FF, 2,  0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus("addFF", 8'hFF, 32'h0000_0020, 0,  2,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("beq0",  8'h00, 32'h1000_0010, 0,  0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0);

    waitReq("final", seen);
    if (seen) checkOutput("final_addr", 32'(imem_addr), 32'h11);
    repeat (2) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
